// File: rtl/mul_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mul_pkg
// Purpose  : Shared types and constants for the sequential carry-save
//            multiplier (FSM state encoding, default operand width, and a
//            helper for sizing the step counter).
// Revision : 1.0 - initial release
// ============================================================================
package mul_pkg;

  // Default operand width; the product is twice this wide.
  localparam int MUL_N = 12;

  // Multiplier sequencing states, explicitly 2 bits wide.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } mul_state_t;

  // Step counter width: enough bits to count 0..n-1, never narrower than 1.
  function automatic int count_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : mul_pkg
`default_nettype wire

// File: rtl/three2add.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : three2add
// Purpose  : Carry-save 3:2 adder. Reduces three (n+1)-bit operands to a
//            (t, s) pair with t + s == x + y + z. Both results are n+2 bits
//            wide; the carry vector t is pre-shifted so t[0] is always 0.
// Revision : 1.0 - initial release
// ============================================================================
module three2add #(
  parameter int n = 12
) (
  input  logic [n:0]   x,
  input  logic [n:0]   y,
  input  logic [n:0]   z,
  output logic [n+1:0] t,
  output logic [n+1:0] s
);

  logic [n:0] w_sum;
  logic [n:0] w_maj;

  // Bitwise full-adder: sum bit and majority (carry) bit per column.
  always_comb begin
    w_sum = x ^ y ^ z;
    w_maj = (x & y) | (x & z) | (y & z);
  end

  // Sum stays in place; carries move up one column, so bit 0 of t is 0.
  assign s = {1'b0, w_sum};
  assign t = {w_maj, 1'b0};

endmodule : three2add
`default_nettype wire

// File: rtl/csa_mul_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : csa_mul_seq
// Purpose  : Sequential unsigned N x N multiplier. The running partial sum is
//            kept in carry-save form (S, C); one multiplier bit is folded in
//            per cycle through a 3:2 adder and one low product bit retires
//            per cycle. A single N-bit carry-propagate add resolves the high
//            half at the end. Valid/ready handshake on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module csa_mul_seq
  import mul_pkg::*;
#(
  parameter int N = MUL_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p
);

  localparam int             CW           = count_width(N);
  localparam logic [CW-1:0]  c_last_count = CW'(N - 1);

  mul_state_t      r_state;
  mul_state_t      w_state_next;

  logic [N-1:0]    r_a;        // latched multiplicand
  logic [N-1:0]    r_b;        // multiplier, shifted right once per step
  logic [N:0]      r_s;        // redundant partial sum: sum vector
  logic [N:0]      r_c;        // redundant partial sum: carry vector
  logic [N-1:0]    r_lo;       // retired low product bits, filled from the top
  logic [CW-1:0]   r_count;    // ACCUM step index
  logic [2*N-1:0]  r_p;        // registered product

  logic [N:0]      w_pp;
  logic [N+1:0]    w_t;
  logic [N+1:0]    w_s;
  logic [N:0]      w_hi_full;
  logic [N-1:0]    w_hi;
  logic            w_last_step;
  logic            w_unused_bits;

  // Current partial product: multiplicand gated by the multiplier LSB.
  always_comb begin
    w_pp = '0;
    if (r_b[0]) begin
      w_pp = {1'b0, r_a};
    end
  end

  three2add #(
    .n (N)
  ) u_three2add (
    .x (r_s),
    .y (r_c),
    .z (w_pp),
    .t (w_t),
    .s (w_s)
  );

  // High half: S + C is bounded below 2^N once all steps are done, so the
  // top bit of the full sum is always 0 and is dropped.
  assign w_hi_full = r_s + r_c;
  assign w_hi      = w_hi_full[N-1:0];

  // t[0] is structurally 0 and the resolve carry-out cannot be set.
  assign w_unused_bits = w_t[0] ^ w_hi_full[N];

  assign w_last_step = (r_count == c_last_count);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (w_last_step) begin
          w_state_next = RESOLVE;
        end
      end
      RESOLVE: begin
        w_state_next = DONE;
      end
      DONE: begin
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Datapath: load on acceptance, one carry-save step per ACCUM cycle,
  // product capture in RESOLVE, hold everywhere else.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_c     <= '0;
      r_lo    <= '0;
      r_count <= '0;
      r_p     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_s     <= '0;
            r_c     <= '0;
            r_lo    <= '0;
            r_count <= '0;
          end
        end
        ACCUM: begin
          // The LSB of the redundant sum is final (t[0] is 0), so it
          // retires into the low half; the rest shifts down one column.
          r_lo    <= {w_s[0], r_lo[N-1:1]};
          r_s     <= w_s[N+1:1];
          r_c     <= w_t[N+1:1];
          r_b     <= r_b >> 1;
          r_count <= r_count + CW'(1);
        end
        RESOLVE: begin
          r_p <= {w_hi, r_lo};
        end
        default: begin
        end
      endcase
    end
  end

  // Handshake outputs decode straight from state; product is registered.
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign p         = r_p;

endmodule : csa_mul_seq
`default_nettype wire

// File: tb/tb_csa_mul_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_csa_mul_seq
// Purpose  : Scoreboard bench for csa_mul_seq (N = 12). The driver pushes the
//            expected product and acceptance cycle; a monitor pops on every
//            output handshake and checks product and latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csa_mul_seq;

  localparam int N       = 12;
  localparam int LATENCY = 13;

  typedef struct {
    logic [2*N-1:0] prod;
    int             acc;
  } exp_t;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] p;

  exp_t q[$];
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   cyc        = 0;
  bit   hold_low   = 0;
  bit   rand_stall = 0;
  bit   prev_valid = 0;

  csa_mul_seq #(
    .N (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter, one tick per rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", q.size());
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Consumer-side ready generation.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_low)        out_ready = 1'b0;
      else if (rand_stall) out_ready = ($urandom_range(0, 3) != 0);
      else                 out_ready = 1'b1;
    end
  end

  // Monitor: latency on the first valid cycle, product on the handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (q.size() == 0) check("unexpected_out_valid", 32'(out_valid), 32'd0);
        else               check("latency", 32'(cyc - q[0].acc), 32'(LATENCY));
      end
      if (out_valid && out_ready && q.size() != 0) begin
        e = q.pop_front();
        check("product", 32'(p), 32'(e.prod));
      end
      prev_valid = out_valid;
    end
  end

  // Present operands and wait for acceptance; records the expected product.
  task automatic issue(input logic [N-1:0] ia, input logic [N-1:0] ib,
                       input logic [2*N-1:0] ep);
    int   waited = 0;
    bit   ok     = 1'b0;
    exp_t e;
    in_valid = 1'b1;
    a        = ia;
    b        = ib;
    while (!ok && waited < 300) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else          waited++;
    end
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      e.prod = ep;
      e.acc  = cyc + 1;
      q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = N'($urandom);
      b        = N'($urandom);
    end
  endtask

  // Wait until every expected product has been seen.
  task automatic drain();
    int waited = 0;
    while (q.size() != 0 && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    if (q.size() != 0) begin
      check("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    int           waited;

    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_p", 32'(p), 32'd0);
    @(posedge clk);
    #1;

    // Basic, maximum operands, zero operands.
    issue(12'd3, 12'd5, 24'd15);
    drain();
    issue(12'd4095, 12'd4095, 24'd16769025);
    drain();
    issue(12'd0, 12'd2730, 24'd0);
    drain();
    issue(12'd2730, 12'd0, 24'd0);
    drain();

    // Backpressure: hold out_ready low for 5 cycles of out_valid.
    hold_low = 1'b1;
    @(posedge clk);
    #2;
    issue(12'd100, 12'd200, 24'd20000);
    waited = 0;
    while (!out_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("bp_valid_seen", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_p_hold", 32'(p), 32'd20000);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_valid_hold", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a        = 12'd1;
      b        = 12'd1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    hold_low = 1'b0;
    drain();
    issue(12'd11, 12'd13, 24'd143);
    drain();

    // Reset five steps into ACCUM discards the operation.
    issue(12'd1234, 12'd567, 24'd699678);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_p", 32'(p), 32'd0);
    @(posedge clk);
    #1;
    issue(12'd7, 12'd9, 24'd63);
    drain();

    // Random operands with random consumer stalls.
    rand_stall = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = N'($urandom_range(0, 4095));
      rb = N'($urandom_range(0, 4095));
      issue(ra, rb, (2*N)'(ra) * (2*N)'(rb));
    end
    drain();
    rand_stall = 1'b0;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_csa_mul_seq
`default_nettype wire
